// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with integrated load-use interlock.
//               Latches decoded control, register specifiers and operands
//               from ID. Generates PC / IF-ID write enables and inserts a
//               single bubble when the instruction in ID reads the
//               destination of a load currently in EX.
//               Optional macro STALL_CNT_EN adds a saturating 32-bit counter
//               of load-use stall cycles on output StallCount.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ExtStall,
  input  logic               Flush,
  input  logic               IfIdValid,
  input  logic [REG_AW-1:0]  IfIdRs,
  input  logic [REG_AW-1:0]  IfIdRt,
  input  logic [REG_AW-1:0]  IfIdRd,
  input  logic [4:0]         IfIdShamt,
  input  logic               IdRegWrite,
  input  logic               IdMemRead,
  input  logic               IdMemWrite,
  input  logic               IdMemToReg,
  input  logic               IdRegDst,
  input  logic               IdAluSrc,
  input  logic [ALUOP_W-1:0] IdAluOp,
  input  logic [DATA_W-1:0]  IdReadData1,
  input  logic [DATA_W-1:0]  IdReadData2,
  input  logic [DATA_W-1:0]  IdImm,
  output logic               IdExValid,
  output logic [REG_AW-1:0]  IdExRs,
  output logic [REG_AW-1:0]  IdExRt,
  output logic [REG_AW-1:0]  IdExRd,
  output logic [4:0]         IdExShamt,
  output logic               IdExRegWrite,
  output logic               IdExMemRead,
  output logic               IdExMemWrite,
  output logic               IdExMemToReg,
  output logic               IdExRegDst,
  output logic               IdExAluSrc,
  output logic [ALUOP_W-1:0] IdExAluOp,
  output logic [DATA_W-1:0]  IdExData1,
  output logic [DATA_W-1:0]  IdExData2,
  output logic [DATA_W-1:0]  IdExImm,
  output logic               PcWrite,
  output logic               IfIdWrite,
  output logic               LoadUseStall
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]        StallCount
`endif
);

  // Load in EX whose destination ($0 excluded) is a source of the ID instruction.
  logic hazard;
  assign hazard = IdExValid & IdExMemRead & IfIdValid & (IdExRt != '0) &
                  ((IdExRt == IfIdRs) | (IdExRt == IfIdRt));

  // Bubble is loaded on flush or load-use; flush takes precedence only in the
  // enables, the register contents are identical either way.
  logic bubble;
  assign bubble = Flush | hazard;

  // Pipeline enables: freeze blocks everything, flush lets the front end run.
  always_comb begin
    PcWrite      = 1'b1;
    IfIdWrite    = 1'b1;
    LoadUseStall = 1'b0;
    if (ExtStall) begin
      PcWrite   = 1'b0;
      IfIdWrite = 1'b0;
    end else if (!Flush && hazard) begin
      PcWrite      = 1'b0;
      IfIdWrite    = 1'b0;
      LoadUseStall = 1'b1;
    end
  end

  // ID/EX register: hold on freeze, bubble on flush/hazard, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IdExValid    <= 1'b0;
      IdExRs       <= '0;
      IdExRt       <= '0;
      IdExRd       <= '0;
      IdExShamt    <= '0;
      IdExRegWrite <= 1'b0;
      IdExMemRead  <= 1'b0;
      IdExMemWrite <= 1'b0;
      IdExMemToReg <= 1'b0;
      IdExRegDst   <= 1'b0;
      IdExAluSrc   <= 1'b0;
      IdExAluOp    <= '0;
      IdExData1    <= '0;
      IdExData2    <= '0;
      IdExImm      <= '0;
    end else if (ExtStall) begin
      // hold all state
    end else if (bubble) begin
      IdExValid    <= 1'b0;
      IdExRs       <= '0;
      IdExRt       <= '0;
      IdExRd       <= '0;
      IdExShamt    <= '0;
      IdExRegWrite <= 1'b0;
      IdExMemRead  <= 1'b0;
      IdExMemWrite <= 1'b0;
      IdExMemToReg <= 1'b0;
      IdExRegDst   <= 1'b0;
      IdExAluSrc   <= 1'b0;
      IdExAluOp    <= '0;
      IdExData1    <= '0;
      IdExData2    <= '0;
      IdExImm      <= '0;
    end else begin
      IdExValid    <= IfIdValid;
      IdExRs       <= IfIdRs;
      IdExRt       <= IfIdRt;
      IdExRd       <= IfIdRd;
      IdExShamt    <= IfIdShamt;
      // Side-effecting controls are gated so forwarding never matches a non-instruction.
      IdExRegWrite <= IdRegWrite & IfIdValid;
      IdExMemRead  <= IdMemRead  & IfIdValid;
      IdExMemWrite <= IdMemWrite & IfIdValid;
      IdExMemToReg <= IdMemToReg;
      IdExRegDst   <= IdRegDst;
      IdExAluSrc   <= IdAluSrc;
      IdExAluOp    <= IdAluOp;
      IdExData1    <= IdReadData1;
      IdExData2    <= IdReadData2;
      IdExImm      <= IdImm;
    end
  end

`ifdef STALL_CNT_EN
  // Saturating count of edges on which a load-use bubble was inserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCount <= '0;
    end else if (LoadUseStall && (StallCount != 32'hFFFF_FFFF)) begin
      StallCount <= StallCount + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage.
//               StallCount checks are compiled only when STALL_CNT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        ExtStall, Flush, IfIdValid;
  logic [4:0]  IfIdRs, IfIdRt, IfIdRd, IfIdShamt;
  logic        IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdRegDst, IdAluSrc;
  logic [3:0]  IdAluOp;
  logic [31:0] IdReadData1, IdReadData2, IdImm;
  logic        IdExValid;
  logic [4:0]  IdExRs, IdExRt, IdExRd, IdExShamt;
  logic        IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExRegDst, IdExAluSrc;
  logic [3:0]  IdExAluOp;
  logic [31:0] IdExData1, IdExData2, IdExImm;
  logic        PcWrite, IfIdWrite, LoadUseStall;
`ifdef STALL_CNT_EN
  logic [31:0] StallCount;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .ALUOP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ExtStall(ExtStall), .Flush(Flush),
    .IfIdValid(IfIdValid), .IfIdRs(IfIdRs), .IfIdRt(IfIdRt), .IfIdRd(IfIdRd),
    .IfIdShamt(IfIdShamt), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdMemWrite(IdMemWrite), .IdMemToReg(IdMemToReg), .IdRegDst(IdRegDst),
    .IdAluSrc(IdAluSrc), .IdAluOp(IdAluOp), .IdReadData1(IdReadData1),
    .IdReadData2(IdReadData2), .IdImm(IdImm), .IdExValid(IdExValid),
    .IdExRs(IdExRs), .IdExRt(IdExRt), .IdExRd(IdExRd), .IdExShamt(IdExShamt),
    .IdExRegWrite(IdExRegWrite), .IdExMemRead(IdExMemRead),
    .IdExMemWrite(IdExMemWrite), .IdExMemToReg(IdExMemToReg),
    .IdExRegDst(IdExRegDst), .IdExAluSrc(IdExAluSrc), .IdExAluOp(IdExAluOp),
    .IdExData1(IdExData1), .IdExData2(IdExData2), .IdExImm(IdExImm),
    .PcWrite(PcWrite), .IfIdWrite(IfIdWrite), .LoadUseStall(LoadUseStall)
`ifdef STALL_CNT_EN
    , .StallCount(StallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running exp finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [31:0] d1);
    IfIdValid = v; IfIdRs = rs; IfIdRt = rt; IfIdRd = rd; IfIdShamt = 5'd0;
    IdRegWrite = rw; IdMemRead = mr; IdMemWrite = mw; IdMemToReg = mr;
    IdRegDst = 1'b0; IdAluSrc = mr | mw; IdAluOp = 4'd0;
    IdReadData1 = d1; IdReadData2 = 32'd0; IdImm = 32'd0;
  endtask

  task automatic idle();
    ExtStall = 1'b0; Flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ExtStall = $urandom; Flush = $urandom; IfIdValid = 1'b1;
    IfIdRs = $urandom; IfIdRt = $urandom; IfIdRd = $urandom; IfIdShamt = $urandom;
    IdRegWrite = 1'b1; IdMemRead = 1'b1; IdMemWrite = 1'b1; IdMemToReg = 1'b1;
    IdRegDst = 1'b1; IdAluSrc = 1'b1; IdAluOp = $urandom;
    IdReadData1 = $urandom; IdReadData2 = $urandom; IdImm = $urandom;
    ExtStall = 1'b0;
    #22;
    checks++; if (IdExValid !== 1'b0) begin $display("FAIL rst_valid: got %b exp 0", IdExValid); errors++; end
    checks++; if ({IdExRs, IdExRt, IdExRd, IdExShamt} !== 20'd0) begin $display("FAIL rst_spec: got %h exp 0", {IdExRs, IdExRt, IdExRd, IdExShamt}); errors++; end
    checks++; if ({IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExRegDst, IdExAluSrc, IdExAluOp} !== 10'd0) begin $display("FAIL rst_ctrl: got %h exp 0", {IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExRegDst, IdExAluSrc, IdExAluOp}); errors++; end
    checks++; if ({IdExData1, IdExData2, IdExImm} !== 96'd0) begin $display("FAIL rst_data: got %h exp 0", {IdExData1, IdExData2, IdExImm}); errors++; end
    checks++; if ({PcWrite, IfIdWrite} !== 2'b11) begin $display("FAIL rst_enables: got %b exp 11", {PcWrite, IfIdWrite}); errors++; end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_capture();
    drive(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 32'h11);
    IfIdShamt = 5'd2; IdAluOp = 4'h5; IdRegDst = 1'b1; IdReadData2 = 32'h22; IdImm = 32'h33;
    #1;
    checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b110) begin $display("FAIL cap_enables: got %b exp 110", {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
    tick();
    checks++; if ({IdExRs, IdExRt, IdExRd, IdExShamt} !== {5'd3, 5'd4, 5'd7, 5'd2}) begin $display("FAIL cap_spec: got %h exp %h", {IdExRs, IdExRt, IdExRd, IdExShamt}, {5'd3, 5'd4, 5'd7, 5'd2}); errors++; end
    checks++; if ({IdExData1, IdExData2, IdExImm} !== {32'h11, 32'h22, 32'h33}) begin $display("FAIL cap_data: got %h exp %h", {IdExData1, IdExData2, IdExImm}, {32'h11, 32'h22, 32'h33}); errors++; end
    checks++; if ({IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite, IdExRegDst, IdExAluOp} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5}) begin $display("FAIL cap_ctrl: got %b exp %b", {IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite, IdExRegDst, IdExAluOp}, {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h5}); errors++; end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 32'hAA);
    #1;
    checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b001) begin $display("FAIL lu_stall: got %b exp 001", {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
    tick();
    checks++; if ({IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite} !== 4'b0000) begin $display("FAIL lu_bubble: got %b exp 0000", {IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite}); errors++; end
    checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b110) begin $display("FAIL lu_release: got %b exp 110", {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
    tick();
    checks++; if ({IdExValid, IdExRs, IdExRegWrite, IdExData1} !== {1'b1, 5'd5, 1'b1, 32'hAA}) begin $display("FAIL lu_advance: got %h exp %h", {IdExValid, IdExRs, IdExRegWrite, IdExData1}, {1'b1, 5'd5, 1'b1, 32'hAA}); errors++; end
    // Load to $0 never stalls
    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd0, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 32'hBB);
    #1;
    checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b110) begin $display("FAIL r0_nostall: got %b exp 110", {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
    tick();
    checks++; if ({IdExValid, IdExRs, IdExData1} !== {1'b1, 5'd0, 32'hBB}) begin $display("FAIL r0_capture: got %h exp %h", {IdExValid, IdExRs, IdExData1}, {1'b1, 5'd0, 32'hBB}); errors++; end
  endtask

  task automatic test_flush_vs_hazard();
    drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 32'hCC);
    Flush = 1'b1;
    #1;
    checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b110) begin $display("FAIL fl_enables: got %b exp 110", {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
    tick();
    Flush = 1'b0;
    checks++; if ({IdExValid, IdExRegWrite, IdExMemRead, IdExData1} !== {4'b0000, 32'h0}) begin $display("FAIL fl_bubble: got %h exp 0", {IdExValid, IdExRegWrite, IdExMemRead, IdExData1}); errors++; end
  endtask

  task automatic test_store_after_load();
    drive(1'b1, 5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h0);
    #1;
    checks++; if (LoadUseStall !== 1'b1) begin $display("FAIL st_stall: got %b exp 1", LoadUseStall); errors++; end
    tick();
    tick();
    checks++; if ({IdExValid, IdExMemWrite, IdExRt} !== {1'b1, 1'b1, 5'd8}) begin $display("FAIL st_advance: got %h exp %h", {IdExValid, IdExMemWrite, IdExRt}, {1'b1, 1'b1, 5'd8}); errors++; end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd9, 5'd10, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    checks++; if (LoadUseStall !== 1'b1) begin $display("FAIL b2b_stall1: got %b exp 1", LoadUseStall); errors++; end
    tick();
    tick();
    checks++; if ({IdExValid, IdExMemRead, IdExRt} !== {1'b1, 1'b1, 5'd10}) begin $display("FAIL b2b_load2: got %h exp %h", {IdExValid, IdExMemRead, IdExRt}, {1'b1, 1'b1, 5'd10}); errors++; end
    drive(1'b1, 5'd1, 5'd10, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (LoadUseStall !== 1'b1) begin $display("FAIL b2b_stall2: got %b exp 1", LoadUseStall); errors++; end
    tick();
    checks++; if (IdExValid !== 1'b0) begin $display("FAIL b2b_bubble2: got %b exp 0", IdExValid); errors++; end
  endtask

  task automatic test_ext_stall();
    drive(1'b1, 5'd3, 5'd4, 5'd7, 1'b1, 1'b0, 1'b0, 32'h11);
    tick();
    for (int i = 0; i < 3; i++) begin
      ExtStall = 1'b1;
      Flush = (i == 1);
      drive(1'b1, 5'd20 + 5'(i), 5'd21, 5'd22, 1'b0, 1'b1, 1'b1, 32'hDEAD_0000 + i);
      #1;
      checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b000) begin $display("FAIL es_enables[%0d]: got %b exp 000", i, {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
      tick();
      checks++; if ({IdExValid, IdExRs, IdExRt, IdExRegWrite, IdExMemRead, IdExData1} !== {1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 32'h11}) begin $display("FAIL es_hold[%0d]: got %h exp %h", i, {IdExValid, IdExRs, IdExRt, IdExRegWrite, IdExMemRead, IdExData1}, {1'b1, 5'd3, 5'd4, 1'b1, 1'b0, 32'h11}); errors++; end
    end
    idle();
    // Freeze during a hazard: stall is deferred until freeze drops
    drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
    ExtStall = 1'b1;
    #1;
    checks++; if ({PcWrite, IfIdWrite, LoadUseStall} !== 3'b000) begin $display("FAIL es_hz_enables: got %b exp 000", {PcWrite, IfIdWrite, LoadUseStall}); errors++; end
    tick();
    ExtStall = 1'b0;
    #1;
    checks++; if ({IdExMemRead, LoadUseStall} !== 2'b11) begin $display("FAIL es_hz_after: got %b exp 11", {IdExMemRead, LoadUseStall}); errors++; end
    tick();
    tick();
  endtask

  task automatic test_invalid_capture();
    drive(1'b0, 5'd12, 5'd13, 5'd14, 1'b1, 1'b1, 1'b1, 32'h55);
    tick();
    checks++; if ({IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite} !== 4'b0000) begin $display("FAIL inv_ctrl: got %b exp 0000", {IdExValid, IdExRegWrite, IdExMemRead, IdExMemWrite}); errors++; end
    checks++; if ({IdExRs, IdExData1} !== {5'd12, 32'h55}) begin $display("FAIL inv_data: got %h exp %h", {IdExRs, IdExData1}, {5'd12, 32'h55}); errors++; end
    // Load in EX but ID holds no instruction: no stall
    drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (LoadUseStall !== 1'b0) begin $display("FAIL inv_nostall: got %b exp 0", LoadUseStall); errors++; end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({IdExValid, IdExMemRead, IdExRt, PcWrite, IfIdWrite, LoadUseStall} !== {1'b0, 1'b0, 5'd0, 3'b110}) begin $display("FAIL rms_state: got %b exp %b", {IdExValid, IdExMemRead, IdExRt, PcWrite, IfIdWrite, LoadUseStall}, {1'b0, 1'b0, 5'd0, 3'b110}); errors++; end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    tick();
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_count();
    checks++; if (StallCount !== 32'd0) begin $display("FAIL cnt_reset: got %0d exp 0", StallCount); errors++; end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick();
      drive(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0);
      if (i == 0) begin
        ExtStall = 1'b1;
        tick();
        ExtStall = 1'b0;
      end
      tick();
      tick();
    end
    checks++; if (StallCount !== 32'd3) begin $display("FAIL cnt_three: got %0d exp 3", StallCount); errors++; end
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_flush_vs_hazard();
    test_store_after_load();
    test_back_to_back();
    test_ext_stall();
    test_invalid_capture();
    test_reset_mid_stall();
`ifdef STALL_CNT_EN
    test_stall_count();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline register with integrated load-use interlock. It sits directly upstream of the EX-stage forwarding unit. It latches decoded control, register specifiers and operands from ID. It presents IdExRs/IdExRt/IdExRd and the control bits that EX and the forwarding unit consume, and it generates the PC / IF-ID write enables for load-use stalls.

Parameters:
DATA_W, 32, operand/immediate width
REG_AW, 5, register specifier width
ALUOP_W, 4, ALU operation code width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
ExtStall  in  1  global freeze (memory wait); hold all state
Flush  in  1  taken branch/jump resolved in EX; kill instruction entering ID/EX
IfIdValid  in  1  IF/ID holds a real instruction
IfIdRs, IfIdRt, IfIdRd  in  REG_AW  decoded specifiers
IfIdShamt  in  5  shift amount
IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg, IdRegDst, IdAluSrc  in  1  decoded control
IdAluOp  in  ALUOP_W  ALU operation
IdReadData1, IdReadData2, IdImm  in  DATA_W  register file reads, sign-extended immediate
IdExValid  out  1  registered valid
IdExRs, IdExRt, IdExRd  out  REG_AW  registered specifiers
IdExShamt  out  5
IdExRegWrite, IdExMemRead, IdExMemWrite, IdExMemToReg, IdExRegDst, IdExAluSrc  out  1
IdExAluOp  out  ALUOP_W
IdExData1, IdExData2, IdExImm  out  DATA_W
PcWrite  out  1  PC update enable (combinational)
IfIdWrite  out  1  IF/ID update enable (combinational)
LoadUseStall  out  1  bubble inserted this cycle (combinational)

Behaviour:
- Reset (rst_n=0, async): all registered outputs 0, including IdExValid=0 and all control bits. Datapath fields also 0. Combinational outputs follow from the zeroed state: PcWrite=1, IfIdWrite=1.
- Hazard detect (combinational): Hz = IdExValid & IdExMemRead & IfIdValid & (IdExRt!=0) & (IdExRt==IfIdRs | IdExRt==IfIdRt).
- Priority per rising edge, first match wins:
  1. ExtStall=1: all registers hold. PcWrite=0, IfIdWrite=0, LoadUseStall=0. Flush is ignored; the source must hold it until ExtStall drops.
  2. Flush=1: load bubble (IdExValid=0, IdExRegWrite/MemRead/MemWrite=0, other fields don't-care but driven 0). PcWrite=1, IfIdWrite=1, LoadUseStall=0. Flush overrides Hz.
  3. Hz=1: load bubble. PcWrite=0, IfIdWrite=0, LoadUseStall=1.
  4. Else: capture all Id*/IfId* inputs; IdExValid<=IfIdValid. PcWrite=1, IfIdWrite=1.
- Invalid capture: if IfIdValid=0, capture with IdExRegWrite, IdExMemRead and IdExMemWrite forced 0. This guarantees the forwarding unit never matches a non-instruction.
- Latency: 1 cycle from ID inputs to IdEx outputs. A load-use stall costs exactly 1 bubble. On the next edge IdExMemRead is 0 (bubble), so Hz clears and the held ID instruction advances.
- Register 0: a load to $0 never stalls.
- Load followed by a store using the loaded value as rt: stalls. No special case.
- Back-to-back loads with a dependency: each stalls one cycle independently.
- Reset mid-stall: outputs return to reset values immediately. The stalled instruction is lost; upstream is reset too.

Optional Feature:
STALL_CNT_EN. When defined, the block adds output StallCount [31:0]. The counter resets to 0 on rst_n=0 and increments on every edge where priority case 3 fires. It saturates at 0xFFFFFFFF and holds during ExtStall. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 with random inputs -> all IdEx* = 0, IdExValid=0, PcWrite=1, IfIdWrite=1.
- Plain capture: IfIdRs=3, IfIdRt=4, IdReadData1=0x11, IdRegWrite=1, valid -> next edge IdExRs=3, IdExData1=0x11, IdExRegWrite=1, IdExValid=1.
- Load-use: lw to rt=5 in ID/EX, next ID instruction rs=5 -> LoadUseStall=1, PcWrite=0, IfIdWrite=0 for one cycle. Bubble has IdExValid=0. The following edge captures the add with IdExRs=5. Repeat with rt=0 -> no stall.
- Flush vs hazard: same load-use setup with Flush=1 -> bubble, PcWrite=1, LoadUseStall=0.
- ExtStall: capture a valid instruction, then hold ExtStall=1 for 3 cycles while changing inputs and pulsing Flush -> outputs unchanged, PcWrite=IfIdWrite=0.
- STALL_CNT_EN: three separate load-use stalls plus one ExtStall cycle during a hazard -> StallCount=3. Preload near-max -> saturates at 0xFFFFFFFF.
